// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU among NREQ requesters
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready  per-requester handshake (req_ready one-hot)
//   req_a/req_b/req_op   packed per-requester operands and ALU control
//   alu_a/alu_b/alu_cont drive to the external ALU; alu_result comes back
//   rsp_valid/rsp_ready  single registered response channel
//   rsp_id/rsp_result/rsp_err  tag, captured result, illegal-opcode flag
//   issue_cnt            wrapping count of accepted operations
module alu_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]    req_op,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_cont,
    input  logic [31:0]          alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_err,
    output logic [15:0]          issue_cnt
);
    typedef enum logic {IDLE, FULL} state_t;
    localparam int             IW1    = IDW + 1;
    localparam logic [IDW:0]   NREQ_W = IW1'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);
    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d;
    logic [31:0]    rsp_result_q, rsp_result_d;
    logic           rsp_err_q, rsp_err_d;
    logic [15:0]    issue_cnt_q, issue_cnt_d;
    logic [31:0]    a_arr [NREQ];
    logic [31:0]    b_arr [NREQ];
    logic [2:0]     op_arr [NREQ];
    logic [NREQ-1:0] rot;
    logic [IDW-1:0] offs, gnt_id, sel;
    logic [IDW:0]   sum;
    logic           issue;
    genvar g;
    for (g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g]  = req_a[32*g +: 32];
        assign b_arr[g]  = req_b[32*g +: 32];
        assign op_arr[g] = req_op[3*g +: 3];
    end
    // Rotate valids so bit 0 is rr_ptr; the lowest set bit is the grant offset.
    always_comb begin
        rot  = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        offs = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) offs = IDW'(k);
        sum    = {1'b0, rr_ptr_q} + {1'b0, offs};
        gnt_id = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
        issue  = (state_q == IDLE || rsp_ready) && (|req_valid);
        sel    = issue ? gnt_id : rr_ptr_q;
    end
    assign req_ready = issue ? NREQ'(1) << gnt_id : '0;
    assign alu_a     = a_arr[sel];
    assign alu_b     = b_arr[sel];
    assign alu_cont  = op_arr[sel];
    // Issue overrides drain, so a drain+issue edge stays FULL with the new response.
    always_comb begin
        state_d      = issue ? FULL : (state_q == FULL && rsp_ready) ? IDLE : state_q;
        rr_ptr_d     = issue ? ((gnt_id == LAST) ? '0 : gnt_id + 1'b1) : rr_ptr_q;
        rsp_id_d     = issue ? gnt_id : rsp_id_q;
        rsp_err_d    = issue ? (alu_cont == 3'b101) : rsp_err_q;
        rsp_result_d = issue ? ((alu_cont == 3'b101) ? '0 : alu_result) : rsp_result_q;
        issue_cnt_d  = issue ? issue_cnt_q + 16'd1 : issue_cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            issue_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            issue_cnt_q  <= issue_cnt_d;
        end
    end
    assign rsp_valid  = (state_q == FULL);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign issue_cnt  = issue_cnt_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter against a reference model
module tb_alu_share_arbiter;
    localparam int N = 4;
    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    valid = '0;
    logic            rsp_ready = 1'b0;
    logic [31:0]     ta [N];
    logic [31:0]     tb [N];
    logic [2:0]      to [N];
    logic [32*N-1:0] req_a, req_b;
    logic [3*N-1:0]  req_op;
    logic [N-1:0]    req_ready;
    logic [31:0]     alu_a, alu_b, alu_result, rsp_result;
    logic [2:0]      alu_cont;
    logic            rsp_valid, rsp_err;
    logic [1:0]      rsp_id;
    logic [15:0]     issue_cnt;
    int pass_n = 0;
    int tot_n = 0;
    bit          m_full;
    int          m_ptr, m_id, m_cnt;
    logic [31:0] m_res;
    bit          m_err;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < N; g++) begin : g_pack
        assign req_a[32*g +: 32] = ta[g];
        assign req_b[32*g +: 32] = tb[g];
        assign req_op[3*g +: 3]  = to[g];
    end

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  return a << b[4:0];
            3'b100:  return a >> b[4:0];
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_cont);

    alu_share_arbiter #(.NREQ(N)) dut (
        .clk(clk), .reset(reset), .req_valid(valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .issue_cnt(issue_cnt)
    );

    function automatic int exp_grant();
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < N; k++)
            if (valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_edge(input int gi);
        if (gi >= 0) begin
            m_full = 1;
            m_id   = gi;
            m_err  = (to[gi] == 3'b101);
            m_res  = m_err ? 32'd0 : alu_fn(ta[gi], tb[gi], to[gi]);
            m_ptr  = (gi + 1) % N;
            m_cnt  = (m_cnt + 1) % 65536;
        end else if (m_full && rsp_ready) m_full = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_full = 0; m_ptr = 0; m_id = 0; m_res = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic test_reset();
        #3;
        tot_n++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else pass_n++;
        tot_n++; if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", rsp_id); else pass_n++;
        tot_n++; if (rsp_result !== 32'd0) $display("FAIL reset_result: got %h want 0", rsp_result); else pass_n++;
        tot_n++; if (rsp_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rsp_err); else pass_n++;
        tot_n++; if (issue_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", issue_cnt); else pass_n++;
        do_reset();
        #1;
        tot_n++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else pass_n++;
    endtask

    task automatic test_single();
        do_reset();
        valid = 4'b0100; ta[2] = 7; tb[2] = 5; to[2] = 3'b110; rsp_ready = 1'b1;
        #1;
        tot_n++; if (req_ready !== 4'b0100) $display("FAIL single_ready: got %b want 0100", req_ready); else pass_n++;
        tot_n++; if (alu_a !== 32'd7 || alu_b !== 32'd5 || alu_cont !== 3'b110)
            $display("FAIL single_alu: got %h %h %b want 7 5 110", alu_a, alu_b, alu_cont); else pass_n++;
        @(posedge clk); #1 valid = '0;
        tot_n++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) $display("FAIL single_rsp: got v%b id%0d want v1 id2", rsp_valid, rsp_id); else pass_n++;
        tot_n++; if (rsp_result !== 32'd2 || rsp_err !== 1'b0) $display("FAIL single_res: got %h e%b want 2 e0", rsp_result, rsp_err); else pass_n++;
        tot_n++; if (issue_cnt !== 16'd1) $display("FAIL single_cnt: got %0d want 1", issue_cnt); else pass_n++;
        @(posedge clk); #1;
        tot_n++; if (rsp_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", rsp_valid); else pass_n++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < N; i++) begin ta[i] = i; tb[i] = 10; to[i] = 3'b010; end
        valid = 4'b1111; rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            tot_n++; if (req_ready !== 4'(1 << (k % N))) $display("FAIL b2b_ready%0d: got %b want %b", k, req_ready, 4'(1 << (k % N))); else pass_n++;
            @(posedge clk); #1;
            tot_n++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % N) || rsp_result !== 32'(10 + k % N))
                $display("FAIL b2b_rsp%0d: got v%b id%0d %0d want v1 id%0d %0d", k, rsp_valid, rsp_id, rsp_result, k % N, 10 + k % N); else pass_n++;
        end
    endtask

    task automatic test_backpressure();
        valid = 4'b0010; rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            tot_n++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b want 0000", k, req_ready); else pass_n++;
            @(posedge clk); #1;
            tot_n++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd10 || issue_cnt !== 16'd5)
                $display("FAIL bp_hold%0d: got v%b id%0d %0d c%0d want v1 id0 10 c5", k, rsp_valid, rsp_id, rsp_result, issue_cnt); else pass_n++;
        end
        rsp_ready = 1'b1;
        #1;
        tot_n++; if (req_ready !== 4'b0010) $display("FAIL bp_release: got %b want 0010", req_ready); else pass_n++;
        @(posedge clk); #1 valid = '0;
        tot_n++; if (rsp_id !== 2'd1 || rsp_result !== 32'd11 || issue_cnt !== 16'd6)
            $display("FAIL bp_rsp: got id%0d %0d c%0d want id1 11 c6", rsp_id, rsp_result, issue_cnt); else pass_n++;
    endtask

    task automatic test_illegal_op();
        do_reset();
        valid = 4'b0001; ta[0] = 3; tb[0] = 4; to[0] = 3'b101; rsp_ready = 1'b1;
        @(posedge clk); #1 to[0] = 3'b111;
        tot_n++; if (rsp_err !== 1'b1 || rsp_result !== 32'd0) $display("FAIL illegal: got e%b %h want e1 0", rsp_err, rsp_result); else pass_n++;
        @(posedge clk); #1 valid = '0;
        tot_n++; if (rsp_err !== 1'b0 || rsp_result !== 32'd1) $display("FAIL slt: got e%b %h want e0 1", rsp_err, rsp_result); else pass_n++;
    endtask

    task automatic test_shift();
        do_reset();
        valid = 4'b0001; ta[0] = 32'h1; tb[0] = 4; to[0] = 3'b011; rsp_ready = 1'b1;
        @(posedge clk); #1 begin ta[0] = 32'h80000000; tb[0] = 31; to[0] = 3'b100; end
        tot_n++; if (rsp_result !== 32'h10) $display("FAIL sll: got %h want 00000010", rsp_result); else pass_n++;
        @(posedge clk); #1 valid = '0;
        tot_n++; if (rsp_result !== 32'h1) $display("FAIL srl: got %h want 00000001", rsp_result); else pass_n++;
    endtask

    task automatic test_async_reset();
        do_reset();
        valid = 4'b0001; ta[0] = 1; tb[0] = 2; to[0] = 3'b010; rsp_ready = 1'b0;
        @(posedge clk); #1;
        tot_n++; if (rsp_valid !== 1'b1) $display("FAIL ar_full: got %b want 1", rsp_valid); else pass_n++;
        #2 reset = 1'b0;
        #1;
        tot_n++; if (rsp_valid !== 1'b0 || issue_cnt !== 16'd0) $display("FAIL ar_clear: got v%b c%0d want v0 c0", rsp_valid, issue_cnt); else pass_n++;
        @(posedge clk); #1 begin reset = 1'b1; valid = 4'b1010; ta[1] = 9; tb[1] = 9; to[1] = 3'b001; rsp_ready = 1'b1; end
        #1;
        tot_n++; if (req_ready !== 4'b0010) $display("FAIL ar_grant: got %b want 0010", req_ready); else pass_n++;
        @(posedge clk); #1 valid = '0;
        tot_n++; if (rsp_id !== 2'd1 || rsp_result !== 32'd9 || issue_cnt !== 16'd1)
            $display("FAIL ar_rsp: got id%0d %0d c%0d want id1 9 c1", rsp_id, rsp_result, issue_cnt); else pass_n++;
    endtask

    task automatic test_random();
        int gi, s;
        do_reset();
        for (int i = 0; i < N; i++) begin
            valid[i] = 1'($urandom); ta[i] = $urandom; tb[i] = $urandom; to[i] = 3'($urandom);
        end
        rsp_ready = 1'($urandom);
        for (int c = 0; c < 400; c++) begin
            #1;
            gi = exp_grant();
            s = (gi >= 0) ? gi : m_ptr;
            tot_n++; if (req_ready !== ((gi >= 0) ? 4'(1 << gi) : 4'b0000))
                $display("FAIL rnd_ready c%0d: got %b want grant %0d", c, req_ready, gi); else pass_n++;
            tot_n++; if (alu_a !== ta[s] || alu_b !== tb[s] || alu_cont !== to[s])
                $display("FAIL rnd_alu c%0d: got %h %h %b want req%0d", c, alu_a, alu_b, alu_cont, s); else pass_n++;
            @(posedge clk);
            model_edge(gi);
            #1;
            tot_n++; if (rsp_valid !== m_full || rsp_id !== 2'(m_id) || rsp_result !== m_res || rsp_err !== m_err || issue_cnt !== 16'(m_cnt))
                $display("FAIL rnd_rsp c%0d: got v%b id%0d %h e%b c%0d want v%b id%0d %h e%b c%0d",
                         c, rsp_valid, rsp_id, rsp_result, rsp_err, issue_cnt, m_full, m_id, m_res, m_err, m_cnt); else pass_n++;
            for (int i = 0; i < N; i++)
                if (!valid[i] || gi == i) begin
                    valid[i] = ($urandom_range(0, 99) < 60);
                    ta[i] = $urandom; tb[i] = $urandom; to[i] = 3'($urandom);
                end
            rsp_ready = ($urandom_range(0, 99) < 70);
        end
        valid = '0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin ta[i] = 0; tb[i] = 0; to[i] = 0; end
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_illegal_op();
        test_shift();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
